// File: rtl/rvfi_csr_shadow_check_if.sv
// rvfi_csr_shadow_check_if: RVFI single-channel retirement signals carrying one CSR's masks and data
interface rvfi_csr_shadow_check_if #(
  parameter int XLEN    = 32,
  parameter int ORDER_W = 64
);
  logic               valid;
  logic [ORDER_W-1:0] order;
  logic               trap;
  logic [XLEN-1:0]    rmask;
  logic [XLEN-1:0]    wmask;
  logic [XLEN-1:0]    rdata;
  logic [XLEN-1:0]    wdata;
  modport master (output valid, order, trap, rmask, wmask, rdata, wdata);
  modport slave  (input  valid, order, trap, rmask, wmask, rdata, wdata);
endinterface

// File: rtl/rvfi_csr_shadow_check.sv
// rvfi_csr_shadow_check: cross-retirement CSR shadow, order-gap and trap-mask checker
// RISCV_FORMAL_CSR_SHADOW_COUNTER_EN makes the shadow a free-running counter while tracking.
module rvfi_csr_shadow_check #(
  parameter int XLEN    = 32,
  parameter int ORDER_W = 64
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               check,
  rvfi_csr_shadow_check_if.slave rvfi,
  output logic [XLEN-1:0]    shadow_known,
  output logic [XLEN-1:0]    shadow_value,
  output logic               check_fail,
  output logic [1:0]         err_code,
  output logic [ORDER_W-1:0] err_order
);
  typedef enum logic [1:0] {IDLE, TRACK, FAIL} state_t;
  state_t             state, state_nx;
  logic [ORDER_W-1:0] last_order;
  logic [XLEN-1:0]    base_known, base_value, known_nx, value_nx;
  logic               gap, mtrap, mism, err, upd;
  logic [1:0]         code;
  always_comb begin
    gap        = state == TRACK && rvfi.order != ORDER_W'(last_order + 1'b1);
    mtrap      = rvfi.trap && |(rvfi.rmask | rvfi.wmask);
    mism       = !rvfi.trap && |((rvfi.rdata ^ shadow_value) & rvfi.rmask & shadow_known);
    code       = gap ? 2'd2 : mtrap ? 2'd3 : mism ? 2'd1 : 2'd0;
    err        = rvfi.valid && state != FAIL && code != 2'd0;
    upd        = rvfi.valid && !rvfi.trap && !err;
`ifdef RISCV_FORMAL_CSR_SHADOW_COUNTER_EN
    // a partially known counter cannot be advanced, so forget it entirely
    base_known = (state == TRACK && !(&shadow_known)) ? '0 : shadow_known;
    base_value = (state == TRACK && &shadow_known) ? shadow_value + 1'b1 : shadow_value;
`else
    base_known = shadow_known;
    base_value = shadow_value;
`endif
    value_nx   = upd ? (rvfi.wmask & rvfi.wdata) | (~rvfi.wmask & rvfi.rmask & rvfi.rdata)
                       | (~(rvfi.wmask | rvfi.rmask) & base_value) : base_value;
    known_nx   = upd ? base_known | rvfi.wmask | rvfi.rmask : base_known;
    state_nx   = state == FAIL ? FAIL : err ? FAIL : rvfi.valid ? TRACK : state;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      shadow_known <= '0;
      shadow_value <= '0;
      check_fail   <= 1'b0;
      err_code     <= 2'd0;
      err_order    <= '0;
      last_order   <= '0;
    end else if (state != FAIL) begin
      if (rvfi.valid) last_order <= rvfi.order;
      if (err) begin
        check_fail <= 1'b1;
        err_code   <= code;
        err_order  <= rvfi.order;
      end else begin
        shadow_known <= known_nx;
        shadow_value <= value_nx;
      end
    end
`ifdef FORMAL
  always_comb if (resetn && check) assert (!check_fail);
`else
  logic unused_check;
  assign unused_check = check;
`endif
endmodule

// File: tb/tb_rvfi_csr_shadow_check.sv
// tb_rvfi_csr_shadow_check: random and directed stimulus against a bit-level behavioural model
module tb_rvfi_csr_shadow_check;
  localparam int XLEN = 32;
  localparam int OW   = 64;
  logic clk = 1'b0, resetn, check;
  logic [XLEN-1:0] shadow_known, shadow_value;
  logic check_fail;
  logic [1:0] err_code;
  logic [OW-1:0] err_order;
  int vectors = 0, miscompares = 0;
  rvfi_csr_shadow_check_if #(.XLEN(XLEN), .ORDER_W(OW)) bus ();
  rvfi_csr_shadow_check #(.XLEN(XLEN), .ORDER_W(OW)) dut (
    .clock(clk), .resetn(resetn), .check(check), .rvfi(bus),
    .shadow_known(shadow_known), .shadow_value(shadow_value),
    .check_fail(check_fail), .err_code(err_code), .err_order(err_order));
  always #5 clk = ~clk;
  logic [XLEN-1:0] m_known, m_val;
  logic [OW-1:0] m_last, m_eo;
  logic [1:0] m_err;
  bit m_seen, m_failed;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_known = '0; m_val = '0; m_last = '0; m_eo = '0; m_err = 0; m_seen = 0; m_failed = 0;
  endtask
  task automatic model_step();
    int code;
    code = 0;
    if (m_failed) return;
    if (bus.valid) begin
      if (m_seen && bus.order != m_last + 64'd1) code = 2;
      else if (bus.trap && (bus.rmask | bus.wmask) != 0) code = 3;
      else if (!bus.trap)
        for (int i = 0; i < XLEN; i++)
          if (bus.rmask[i] && m_known[i] && bus.rdata[i] != m_val[i]) code = 1;
    end
    if (code != 0) begin
      m_failed = 1; m_err = 2'(code); m_eo = bus.order;
      return;
    end
`ifdef RISCV_FORMAL_CSR_SHADOW_COUNTER_EN
    if (m_seen) begin
      if (m_known == '1) m_val = m_val + 1;
      else m_known = '0;
    end
`endif
    if (bus.valid) begin
      if (!bus.trap)
        for (int i = 0; i < XLEN; i++)
          if (bus.wmask[i]) begin m_val[i] = bus.wdata[i]; m_known[i] = 1'b1; end
          else if (bus.rmask[i]) begin m_val[i] = bus.rdata[i]; m_known[i] = 1'b1; end
      m_last = bus.order;
      m_seen = 1;
    end
  endtask
  task automatic compare_all();
    chk("shadow_known", 64'(shadow_known), 64'(m_known));
    chk("shadow_value", 64'(shadow_value), 64'(m_val));
    chk("check_fail", 64'(check_fail), 64'(m_failed));
    chk("err_code", 64'(err_code), 64'(m_err));
    chk("err_order", err_order, m_eo);
  endtask
  task automatic drive(input logic v, input logic [OW-1:0] o, input logic t,
                       input logic [XLEN-1:0] rm, wm, rd, wd);
    bus.valid = v; bus.order = o; bus.trap = t;
    bus.rmask = rm; bus.wmask = wm; bus.rdata = rd; bus.wdata = wd;
  endtask
  task automatic step(input logic v, input logic [OW-1:0] o, input logic t,
                      input logic [XLEN-1:0] rm, wm, rd, wd);
    drive(v, o, t, rm, wm, rd, wd);
    @(posedge clk);
    model_step();
    #1 compare_all();
    @(negedge clk);
  endtask
  task automatic pulse_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    @(posedge clk);
    model_reset();
    #1 compare_all();
    @(negedge clk);
    resetn = 1'b1;
  endtask
  initial begin
    logic [OW-1:0] o;
    logic [XLEN-1:0] rm, wm, rd;
    logic t;
    resetn = 1'b0; check = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset_known", 64'(shadow_known), 64'h0);
    chk("reset_value", 64'(shadow_value), 64'h0);
    chk("reset_fail", 64'(check_fail), 64'h0);
    chk("reset_code", 64'(err_code), 64'h0);
    chk("reset_order", err_order, 64'h0);
    resetn = 1'b1;
`ifndef RISCV_FORMAL_CSR_SHADOW_COUNTER_EN
    step(1, 5, 0, 0, '1, 0, 32'h1234);
    step(1, 6, 0, '1, 0, 32'h1234, 0);
    chk("learn_fail", 64'(check_fail), 64'h0);
    chk("learn_value", 64'(shadow_value), 64'h1234);
    chk("learn_known", 64'(shadow_known), 64'hffff_ffff);
    step(1, 7, 0, 32'hff, 0, 32'h35, 0);
    chk("mism_fail", 64'(check_fail), 64'h1);
    chk("mism_code", 64'(err_code), 64'h1);
    chk("mism_order", err_order, 64'd7);
    step(1, 9, 1, '1, 0, 0, 0);
    chk("sticky_code", 64'(err_code), 64'h1);
    chk("sticky_order", err_order, 64'd7);
    chk("frozen_value", 64'(shadow_value), 64'h1234);
    pulse_reset();
    step(1, 10, 0, 0, 0, 0, 0);
    step(1, 11, 0, 0, 0, 0, 0);
    step(1, 13, 0, 0, 0, 0, 0);
    chk("gap_code", 64'(err_code), 64'h2);
    chk("gap_order", err_order, 64'd13);
`else
    step(1, 5, 0, 0, '1, 0, 32'hffff_fffe);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("ctr_value", 64'(shadow_value), 64'h0);
    step(1, 6, 0, '1, 0, 32'h0, 0);
    chk("ctr_wrap_fail", 64'(check_fail), 64'h0);
    pulse_reset();
    step(1, 5, 0, 0, '1, 0, 32'hffff_fffe);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 6, 0, '1, 0, 32'hffff_ffff, 0);
    chk("ctr_bad_code", 64'(err_code), 64'h1);
    chk("ctr_bad_order", err_order, 64'd6);
`endif
    pulse_reset();
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 2, 1, 32'h1, 0, 0, 0);
    chk("trap_code", 64'(err_code), 64'h3);
    pulse_reset();
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 3, 1, 32'h1, 0, 0, 0);
    chk("prio_code", 64'(err_code), 64'h2);
    chk("prio_order", err_order, 64'd3);
    drive(1, 50, 0, '1, '1, 32'h5, 32'h7);
    #2 resetn = 1'b0;
    #1;
    chk("async_fail", 64'(check_fail), 64'h0);
    chk("async_code", 64'(err_code), 64'h0);
    chk("async_order", err_order, 64'h0);
    chk("async_known", 64'(shadow_known), 64'h0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    step(1, 100, 0, 0, 0, 0, 0);
    step(1, 101, 0, 0, 0, 0, 0);
    chk("rearm_fail", 64'(check_fail), 64'h0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0 || (m_failed && $urandom_range(0, 3) == 0)) pulse_reset();
      if (!m_seen) o = ($urandom_range(0, 3) == 0) ? 64'hffff_ffff_ffff_fffe : {$urandom, $urandom};
      else o = m_last + 64'd1;
      if ($urandom_range(0, 39) == 0) o = o + 64'($urandom_range(1, 3));
      t = $urandom_range(0, 14) == 0;
      rm = $urandom & $urandom;
      wm = $urandom & $urandom & $urandom;
      if (t && $urandom_range(0, 2) != 0) begin rm = 0; wm = 0; end
      rd = (m_val & m_known) | ($urandom & ~m_known);
      if ($urandom_range(0, 24) == 0) rd = rd ^ (32'h1 << $urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, o, t, rm, wm, rd, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rvfi_csr_shadow_check.md
Name: rvfi_csr_shadow_check

Overview:
- Sequential RVFI consumer placed beside the per-instruction CSR write check on a single retirement channel.
- Keeps a per-bit shadow of one CSR across retirements, learning bits from observed reads and writes.
- Flags any retirement whose CSR rdata contradicts the shadow, any gap in the retirement order, and any trapped retirement that reports CSR access.
- Supplies the cross-instruction continuity the single-instruction check cannot see.

Parameters:
XLEN, 32, CSR and data width in bits (32 or 64)
ORDER_W, 64, width of rvfi_order

Ports:
clock  in  1  sole clock; all state updates on rising edge
resetn  in  1  asynchronous, active-low reset
check  in  1  when high, the formal assertion on check_fail is active
rvfi_valid  in  1  retirement strobe
rvfi_order  in  ORDER_W  retirement index
rvfi_trap  in  1  retirement trapped
rvfi_csr_rmask  in  XLEN  CSR bits read
rvfi_csr_wmask  in  XLEN  CSR bits written
rvfi_csr_rdata  in  XLEN  CSR value before the instruction
rvfi_csr_wdata  in  XLEN  CSR value after the instruction
shadow_known  out  XLEN  per-bit "shadow holds a valid value"
shadow_value  out  XLEN  shadow CSR value
check_fail  out  1  sticky error flag
err_code  out  2  0 none, 1 data mismatch, 2 order gap, 3 mask on trap
err_order  out  ORDER_W  rvfi_order of the first failing retirement

Behaviour:
- Reset (asynchronous, resetn low): state=IDLE.
  - shadow_known=0, shadow_value=0, check_fail=0, err_code=0, err_order=0, last_order=0.
  - Effect is immediate and aborts any in-flight evaluation.
- States:
  - IDLE: no retirement seen yet.
  - TRACK: shadow active.
  - FAIL: sticky; only resetn leaves FAIL.
- IDLE -> TRACK on the first rvfi_valid. No order check on this retirement; last_order := rvfi_order.
- In TRACK, every rvfi_valid retirement is evaluated in that cycle. Errors are registered and visible the next cycle.
- Error detection, in priority order (highest priority wins when several fire in the same cycle):
  1. Order gap: rvfi_order != last_order+1 (modulo 2^ORDER_W) -> code 2.
  2. Mask on trap: rvfi_trap && (rmask|wmask) != 0 -> code 3.
  3. Data mismatch: !trap && ((rvfi_csr_rdata ^ shadow_value) & rvfi_csr_rmask & shadow_known) != 0 -> code 1.
- On any error: state := FAIL, check_fail := 1, err_code := code, err_order := rvfi_order. Shadow and other outputs freeze in FAIL.
- Shadow update on a non-trapping valid retirement with no error:
  - Bits with wmask=1: value := wdata bit, known := 1.
  - Else bits with rmask=1: value := rdata bit, known := 1.
  - Other bits unchanged.
- Trapped retirements with no error: only last_order updates; shadow unchanged.
- last_order := rvfi_order on every valid retirement in TRACK.
- rvfi_valid low: no state change, except the counter increment when the optional feature is enabled.
- Formal: under FORMAL, assert(!check_fail) whenever resetn && check.

Optional Feature:
RISCV_FORMAL_CSR_SHADOW_COUNTER_EN
- Defined:
  - Shadow models a free-running counter (mcycle-style).
  - In TRACK, every clock cycle shadow_value increments by 1, wrapping at 2^XLEN, before any same-cycle retirement update.
  - A same-cycle wmask write overrides the increment bit-wise.
  - The increment applies only when shadow_known is all ones; otherwise known is cleared to 0.
  - The rdata comparison uses the pre-increment value.
- Undefined: shadow holds its value between retirements.

Test Plan:
- Reset, then retire order 5 with wmask=FFFFFFFF, wdata=0x1234, then order 6 with rmask=FFFFFFFF, rdata=0x1234 -> check_fail stays 0; shadow_value=0x1234, shadow_known=FFFFFFFF.
- After that, order 7 with rmask=0x000000FF, rdata=0x00000035 -> next cycle check_fail=1, err_code=1, err_order=7; later retirements ignored.
- Orders 10, 11, 13 with no CSR access -> err_code=2, err_order=13.
- Trapped retirement with rmask=0x1 -> err_code=3. Same retirement also with an order gap -> err_code=2 (priority).
- Drop resetn mid-retirement while in FAIL -> all outputs 0 immediately; next valid retirement re-enters TRACK with no order error.
- COUNTER_EN: write 0xFFFFFFFE, two idle cycles, then read rdata=0x00000000 -> pass (wrap). Same sequence with rdata=0xFFFFFFFF -> err_code=1.
